init_sequencer: RTL and testbench
=================================

# init_sequencer

Power-on initialisation sequencer that sits directly downstream of the power-up start-delay stage. It waits for the delayed `start` level, then walks a command ROM. Each entry either sends a byte to the display/peripheral byte writer over a valid/ready handshake, inserts a timed pause, or terminates. It reports completion (`init_done`) and malformed-ROM errors (`init_err`) to the game top level.

## Interface
- `ROM_DEPTH`, 64: number of ROM entries; address width is clog2(`ROM_DEPTH`).
- `DELAY_UNIT`, 25000: clock cycles per wait unit.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level from the start-delay stage; goes high once and stays high.
- `rom_addr`  out  clog2(ROM_DEPTH)  registered ROM address.
- `rom_data`  in  16  synchronous ROM output; valid one cycle after `rom_addr` changes.
- `tx_valid`  out  1  byte offered to the writer.
- `tx_ready`  in  1  writer accepts the byte.
- `tx_data`  out  8  byte payload.
- `tx_dc`  out  1  0 = command byte, 1 = data byte.
- `busy`  out  1  high from sequence start until DONE.
- `init_done`  out  1  sticky high once the sequence ends.
- `init_err`  out  1  sticky high if the ROM ran out without an END entry.

## Operation
- Entry format: `rom_data[15:14]` is the opcode, `[7:0]` is the argument, `[13:8]` are ignored.
  - 00 SEND_CMD: send arg with `tx_dc=0`.
  - 01 SEND_DATA: send arg with `tx_dc=1`.
  - 10 WAIT: pause arg × `DELAY_UNIT` cycles.
  - 11 END.
- States are IDLE, FETCH, DECODE, SEND, WAIT, DONE.
- IDLE: leave on the first edge that samples `start=1`; go to FETCH and set `busy=1`.
- FETCH: one cycle, so that `rom_data` is valid for the current `rom_addr`. Then go to DECODE.
- DECODE: sample `rom_data`.
  - SEND_*: load `tx_data`/`tx_dc`, set `tx_valid=1`, go to SEND.
  - WAIT with arg=0: ADVANCE immediately, with no WAIT cycles.
  - WAIT with arg≠0: load the counters and go to WAIT.
  - END: go to DONE.
- SEND: hold until an edge where `tx_valid && tx_ready`. On that edge clear `tx_valid` and ADVANCE.
- WAIT: two nested down-counters, unit (`DELAY_UNIT`) and repeat (arg). No multiplier.
  - The state lasts exactly arg × `DELAY_UNIT` cycles, then ADVANCE.
- ADVANCE:
  - If `rom_addr == ROM_DEPTH-1`: go to DONE and set `init_err=1`.
  - Otherwise: `rom_addr+1`, go to FETCH.
- DONE: `busy=0`, `init_done=1`, `tx_valid=0`. Held until reset; `start` is ignored.
- `start` is sampled only in IDLE. Deassertion mid-sequence has no effect.

## Timing
- Reset values, applied asynchronously the instant `rst_n=0`:
  - state IDLE, `rom_addr=0`, `tx_valid=0`, `tx_data=0`, `tx_dc=0`, `busy=0`, `init_done=0`, `init_err=0`, counters 0.
- Reset mid-operation: `tx_valid` drops immediately and the in-flight byte is abandoned. After release with `start` high, the sequence restarts from address 0.
- Start latency:
  - edge E0 samples `start=1` (IDLE→FETCH);
  - E1: FETCH→DECODE;
  - E2: `tx_valid` registers high.
  - For entry 0 being a send, `tx_valid` is therefore visible after 3 edges.
- Inter-entry overhead: 2 cycles (FETCH + DECODE) between an accepted transfer, or the end of a WAIT, and the next `tx_valid`/WAIT.
- Handshake:
  - While `tx_valid=1 && tx_ready=0`, `tx_data` and `tx_dc` stay stable.
  - `tx_ready` high before `tx_valid` is allowed; the transfer occurs on the first edge where both are high.
  - Exactly one transfer per SEND entry; `tx_valid` is never high for 2 consecutive accepted edges.
- `init_done`/`busy` update on the same edge that enters DONE.

## Test plan
- No start: hold `start=0` for 200 cycles after reset → every output stays at its reset value and `rom_addr=0`.
- Basic sequence: ROM {0x0011, 0x4055, 0xC000}, `tx_ready=1` →
  - transfers (0x11, dc0) then (0x55, dc1);
  - first `tx_valid` 3 edges after `start`;
  - then `init_done=1`, `init_err=0`, `busy=0`.
- Backpressure: same ROM, `tx_ready` low for 10 cycles after the first `tx_valid` → `tx_valid`, 0x11 and dc0 stay stable for all 10 cycles, followed by a single transfer and no duplicate.
- Wait timing: `DELAY_UNIT=4`, ROM {0x0001, 0x8003, 0x8000, 0x0002, 0xC000} →
  - WAIT lasts exactly 12 cycles;
  - the arg-0 entry adds only FETCH+DECODE;
  - the second `tx_valid` appears 18 cycles after the first transfer edge.
- Missing END: `ROM_DEPTH=4`, all four entries SEND_CMD → 4 transfers, then `init_done=1`, `init_err=1`, and `rom_addr` does not wrap.
- Reset mid-WAIT and mid-SEND (with `tx_ready=0`) → outputs clear without waiting for a clock edge. After release, the sequence replays from 0x0011.

Source files
------------

// File: rtl/init_sequencer.sv
// init_sequencer
//
// Power-on initialisation sequencer. Once the delayed `start` level is seen it
// walks a command ROM. Each 16-bit entry carries an opcode in [15:14] and an
// argument in [7:0]:
//   00 SEND_CMD  : send arg as a command byte (tx_dc = 0)
//   01 SEND_DATA : send arg as a data byte    (tx_dc = 1)
//   10 WAIT      : pause arg * DELAY_UNIT cycles (arg = 0 means no pause)
//   11 END       : sequence complete
// Running off the last ROM address without an END entry finishes the sequence
// with init_err set.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level from the start-delay stage, sampled only while idle
//   rom_addr   out  registered ROM address
//   rom_data   in   synchronous ROM word, valid one cycle after rom_addr changes
//   tx_valid   out  byte offered to the byte writer
//   tx_ready   in   byte writer accepts the offered byte
//   tx_data    out  byte payload
//   tx_dc      out  0 = command byte, 1 = data byte
//   busy       out  high from sequence start until completion
//   init_done  out  sticky completion flag
//   init_err   out  sticky flag: ROM exhausted without an END entry
module init_sequencer #(
  parameter int ROM_DEPTH  = 64,
  parameter int DELAY_UNIT = 25000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
  input  logic [15:0]                  rom_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_dc,
  output logic                         busy,
  output logic                         init_done,
  output logic                         init_err
);

  localparam int AW = $clog2(ROM_DEPTH);
  localparam int UW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(ROM_DEPTH - 1);
  localparam logic [UW-1:0] UNIT_RELOAD = UW'(DELAY_UNIT - 1);

  localparam logic [1:0] OP_CMD  = 2'b00;
  localparam logic [1:0] OP_DATA = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0] rom_addr_nxt;
  logic          tx_valid_nxt;
  logic [7:0]    tx_data_nxt;
  logic          tx_dc_nxt;
  logic          busy_nxt;
  logic          init_done_nxt;
  logic          init_err_nxt;

  // unit_cnt counts cycles inside one DELAY_UNIT, rep_cnt counts remaining
  // units; both count down to zero so the pause needs no multiplier.
  logic [UW-1:0] unit_cnt;
  logic [UW-1:0] unit_cnt_nxt;
  logic [7:0]    rep_cnt;
  logic [7:0]    rep_cnt_nxt;

  logic [1:0] op;
  logic [7:0] arg;
  logic       unused_rom_bits;
  logic       wait_expired;
  logic       advance;
  logic       at_last;

  assign op              = rom_data[15:14];
  assign arg             = rom_data[7:0];
  assign unused_rom_bits = ^rom_data[13:8];

  assign wait_expired = (unit_cnt == '0) && (rep_cnt == '0);
  assign at_last      = (rom_addr == LAST_ADDR);

  // An entry is finished (ADVANCE) on: a zero-length WAIT at decode, an
  // accepted transfer, or the final cycle of a WAIT.
  assign advance = ((state == S_DECODE) && (op == OP_WAIT) && (arg == 8'd0)) ||
                   ((state == S_SEND) && tx_valid && tx_ready) ||
                   ((state == S_WAIT) && wait_expired);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_CMD, OP_DATA: state_nxt = S_SEND;
          OP_WAIT: begin
            if (arg != 8'd0) begin
              state_nxt = S_WAIT;
            end
          end
          default: state_nxt = S_DONE;
        endcase
      end
      S_SEND:  state_nxt = S_SEND;
      S_WAIT:  state_nxt = S_WAIT;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase

    // The last address has no successor: finish instead of wrapping.
    if (advance) begin
      state_nxt = at_last ? S_DONE : S_FETCH;
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    rom_addr_nxt  = rom_addr;
    tx_valid_nxt  = tx_valid;
    tx_data_nxt   = tx_data;
    tx_dc_nxt     = tx_dc;
    busy_nxt      = busy;
    init_done_nxt = init_done;
    init_err_nxt  = init_err;
    unit_cnt_nxt  = unit_cnt;
    rep_cnt_nxt   = rep_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        if ((op == OP_CMD) || (op == OP_DATA)) begin
          tx_data_nxt  = arg;
          tx_dc_nxt    = op[0];
          tx_valid_nxt = 1'b1;
        end else if ((op == OP_WAIT) && (arg != 8'd0)) begin
          unit_cnt_nxt = UNIT_RELOAD;
          rep_cnt_nxt  = arg - 8'd1;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (unit_cnt != '0) begin
          unit_cnt_nxt = unit_cnt - UW'(1);
        end else if (rep_cnt != 8'd0) begin
          rep_cnt_nxt  = rep_cnt - 8'd1;
          unit_cnt_nxt = UNIT_RELOAD;
        end
      end
      default: begin
      end
    endcase

    if (advance) begin
      if (at_last) begin
        init_err_nxt = 1'b1;
      end else begin
        rom_addr_nxt = rom_addr + AW'(1);
      end
    end

    // Status flags change on the same edge that enters DONE.
    if (state_nxt == S_DONE) begin
      busy_nxt      = 1'b0;
      init_done_nxt = 1'b1;
      tx_valid_nxt  = 1'b0;
    end
  end

  // Output / datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'd0;
      tx_dc     <= 1'b0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      unit_cnt  <= '0;
      rep_cnt   <= 8'd0;
    end else begin
      rom_addr  <= rom_addr_nxt;
      tx_valid  <= tx_valid_nxt;
      tx_data   <= tx_data_nxt;
      tx_dc     <= tx_dc_nxt;
      busy      <= busy_nxt;
      init_done <= init_done_nxt;
      init_err  <= init_err_nxt;
      unit_cnt  <= unit_cnt_nxt;
      rep_cnt   <= rep_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
module tb_init_sequencer;

  localparam int DU = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        tx_ready;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        busy;
  logic        init_done;
  logic        init_err;

  logic        start4;
  logic        tx_ready4;
  logic [1:0]  rom_addr4;
  logic [15:0] rom_data4;
  logic        tx_valid4;
  logic [7:0]  tx_data4;
  logic        tx_dc4;
  logic        busy4;
  logic        init_done4;
  logic        init_err4;

  init_sequencer #(.ROM_DEPTH(64), .DELAY_UNIT(DU)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_dc(tx_dc), .busy(busy), .init_done(init_done),
    .init_err(init_err)
  );

  init_sequencer #(.ROM_DEPTH(4), .DELAY_UNIT(DU)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .rom_addr(rom_addr4),
    .rom_data(rom_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
    .tx_data(tx_data4), .tx_dc(tx_dc4), .busy(busy4), .init_done(init_done4),
    .init_err(init_err4)
  );

  // Synchronous ROM models
  logic [15:0] rom  [64];
  logic [15:0] rom4 [4];
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data4 <= rom4[rom_addr4];
  end

  typedef struct packed {
    logic [7:0] data;
    logic       dc;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t exp4_q[$];
  xfer_t obs_q[$];
  xfer_t obs4_q[$];
  int    obs_edge[$];
  int    addr_edge[64];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a transfer is seen at the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        obs_q.push_back(xfer_t'({tx_data, tx_dc}));
        obs_edge.push_back(cyc + 1);
      end
      if (tx_valid4 && tx_ready4) begin
        obs4_q.push_back(xfer_t'({tx_data4, tx_dc4}));
      end
      if (addr_edge[rom_addr] < 0) begin
        addr_edge[rom_addr] <= cyc;
      end
    end
  end

  task automatic clear_sb();
    obs_q.delete();
    obs4_q.delete();
    obs_edge.delete();
    exp_q.delete();
    exp4_q.delete();
    for (int i = 0; i < 64; i++) addr_edge[i] = -1;
  endtask

  task automatic load_rom(input logic [15:0] img[$]);
    for (int i = 0; i < 64; i++) rom[i] = 16'hC000;
    for (int i = 0; i < img.size(); i++) begin
      rom[i] = img[i];
      if (img[i][15] == 1'b0) exp_q.push_back(xfer_t'({img[i][7:0], img[i][14]}));
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    start4    = 1'b0;
    tx_ready  = 1'b0;
    tx_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_sb();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(input bit which4, input int bound, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((which4 ? init_done4 : init_done) == 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; tx_ready = 1'b0; tx_ready4 = 1'b0;
    #3;
    total++;
    if ({rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err});
    end
    total++;
    if ({rom_addr4, tx_valid4, tx_data4, tx_dc4, busy4, init_done4, init_err4} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs4 got=%h want=0", {rom_addr4, tx_valid4, tx_data4, tx_dc4, busy4, init_done4, init_err4});
    end
    apply_reset();
  endtask

  task automatic test_no_start();
    apply_reset();
    load_rom('{16'h0011, 16'h4055, 16'hC000});
    tx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      total++;
      if ({rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err} !== 19'd0) begin
        bad++;
        $display("FAIL no_start cycle=%0d got=%h want=0", i, {rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err});
      end
    end
  endtask

  task automatic test_basic();
    bit    to;
    int    base;
    xfer_t e, o;
    apply_reset();
    load_rom('{16'h0011, 16'h4055, 16'hC000});
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    base  = cyc;
    wait_valid(20, to);
    total++;
    if (to || (cyc - base) != 3) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=3 timeout=%0b", cyc - base, to);
    end
    wait_done(1'b0, 100, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL basic_done_timeout got=1 want=0"); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL basic_xfer got=%h want=%h", o, e); end
    end
    total++;
    if ({init_done, init_err, busy, tx_valid} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_status got=%b want=1000", {init_done, init_err, busy, tx_valid});
    end
  endtask

  task automatic test_backpressure();
    bit    to;
    xfer_t e, o;
    apply_reset();
    load_rom('{16'h0011, 16'h4055, 16'hC000});
    tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    wait_valid(20, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL bp_valid_timeout got=1 want=0"); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({tx_valid, tx_data, tx_dc} !== {1'b1, 8'h11, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got=%h want=%h", i, {tx_valid, tx_data, tx_dc}, {1'b1, 8'h11, 1'b0});
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_done(1'b0, 100, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL bp_done_timeout got=1 want=0"); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL bp_xfer got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_wait_timing();
    bit    to;
    int    gap;
    xfer_t e, o;
    apply_reset();
    load_rom('{16'h0001, 16'h8003, 16'h8000, 16'h0002, 16'hC000});
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    wait_done(1'b0, 200, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL wait_done_timeout got=1 want=0"); end
    total++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL wait_count got=%0d want=2", obs_q.size());
    end else begin
      gap = obs_edge[1] - obs_edge[0];
      total++;
      if (gap != 19) begin bad++; $display("FAIL wait_xfer_gap got=%0d want=19", gap); end
    end
    total++;
    if (addr_edge[2] - addr_edge[1] != 14) begin
      bad++;
      $display("FAIL wait_len got=%0d want=14", addr_edge[2] - addr_edge[1]);
    end
    total++;
    if (addr_edge[3] - addr_edge[2] != 2) begin
      bad++;
      $display("FAIL wait_zero got=%0d want=2", addr_edge[3] - addr_edge[2]);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL wait_xfer got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_missing_end();
    bit    to;
    xfer_t e, o;
    apply_reset();
    rom4[0] = 16'h000A; rom4[1] = 16'h000B; rom4[2] = 16'h000C; rom4[3] = 16'h000D;
    for (int i = 0; i < 4; i++) exp4_q.push_back(xfer_t'({rom4[i][7:0], 1'b0}));
    tx_ready4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b1;
    wait_done(1'b1, 100, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL noend_done_timeout got=1 want=0"); end
    total++;
    if (obs4_q.size() != 4) begin bad++; $display("FAIL noend_count got=%0d want=4", obs4_q.size()); end
    while (exp4_q.size() > 0 && obs4_q.size() > 0) begin
      e = exp4_q.pop_front();
      o = obs4_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL noend_xfer got=%h want=%h", o, e); end
    end
    total++;
    if ({init_done4, init_err4, busy4, tx_valid4} !== 4'b1100) begin
      bad++;
      $display("FAIL noend_status got=%b want=1100", {init_done4, init_err4, busy4, tx_valid4});
    end
    repeat (20) @(negedge clk);
    total++;
    if (rom_addr4 !== 2'd3 || obs4_q.size() != 0) begin
      bad++;
      $display("FAIL noend_nowrap addr=%0d extra=%0d want addr=3 extra=0", rom_addr4, obs4_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit    to;
    xfer_t e, o;
    logic [15:0] img[$];
    img = '{16'h0011, 16'h8005, 16'h4055, 16'hC000};
    apply_reset();
    load_rom(img);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    // Reset in the middle of the WAIT entry
    repeat (12) @(negedge clk);
    total++;
    if ({busy, tx_valid, rom_addr} !== {1'b1, 1'b0, 6'd1}) begin
      bad++;
      $display("FAIL midwait_state got=%h want=%h", {busy, tx_valid, rom_addr}, {1'b1, 1'b0, 6'd1});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err} !== 19'd0) begin
      bad++;
      $display("FAIL midwait_clear got=%h want=0", {rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err});
    end
    repeat (2) @(posedge clk); #1;
    clear_sb();
    load_rom(img);
    tx_ready = 1'b0;
    rst_n = 1'b1;
    // Replay with backpressure, then reset while the first byte is offered
    wait_valid(20, to);
    total++;
    if (to || {tx_data, tx_dc} !== {8'h11, 1'b0}) begin
      bad++;
      $display("FAIL replay_first got=%h want=%h timeout=%0b", {tx_data, tx_dc}, {8'h11, 1'b0}, to);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err} !== 19'd0) begin
      bad++;
      $display("FAIL midsend_clear got=%h want=0", {rom_addr, tx_valid, tx_data, tx_dc, busy, init_done, init_err});
    end
    repeat (2) @(posedge clk); #1;
    clear_sb();
    load_rom(img);
    tx_ready = 1'b1;
    rst_n = 1'b1;
    wait_done(1'b0, 200, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL replay_done_timeout got=1 want=0"); end
    total++;
    if (obs_q.size() != 2) begin bad++; $display("FAIL replay_count got=%0d want=2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL replay_xfer got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'hC000;
      addr_edge[i] = -1;
    end
    for (int i = 0; i < 4; i++) rom4[i] = 16'hC000;
    test_reset();
    test_no_start();
    test_basic();
    test_backpressure();
    test_wait_timing();
    test_missing_end();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
